// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding
// and the double-dabble digit adjust constants.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    import bin2bcd_pkg::*;

    // Add-3 correction ahead of the shift
    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH) begin
            dout = din + BCD_ADJ_ADD;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift-and-adjust step per clock.
// Optional BIN2BCD_BLANK_EN adds a leading-zero blanking mask output.
module bin2bcd_seq #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);
    import bin2bcd_pkg::*;

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_e             state_r, state_s;
    logic [IN_W-1:0]    shreg_r, shreg_s;
    logic [SCR_W-1:0]   scratch_r, scratch_s;
    logic [SCR_W-1:0]   adj_s;
    logic               ovf_scr_r, ovf_scr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r;
    logic               done_r;
    logic [SCR_W-1:0]   bcd_r;
    logic               overflow_r;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (scratch_r[4*g +: 4]),
                .dout (adj_s[4*g +: 4])
            );
        end
    endgenerate

    // Next-state and datapath update for the conversion FSM
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        scratch_s = scratch_r;
        ovf_scr_s = ovf_scr_r;
        cnt_s     = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    shreg_s   = bin;
                    scratch_s = {SCR_W{1'b0}};
                    ovf_scr_s = 1'b0;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = SHIFT;
                end else begin
                    state_s   = IDLE;
                end
            end
            SHIFT: begin
                // Anything carried out of the top digit means the value is too wide
                scratch_s = {adj_s[SCR_W-2:0], shreg_r[IN_W-1]};
                shreg_s   = {shreg_r[IN_W-2:0], 1'b0};
                ovf_scr_s = ovf_scr_r | adj_s[SCR_W-1];
                cnt_s     = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_s = FINISH;
                end else begin
                    state_s = SHIFT;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Scratch datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_r   <= {IN_W{1'b0}};
            scratch_r <= {SCR_W{1'b0}};
            ovf_scr_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            shreg_r   <= shreg_s;
            scratch_r <= scratch_s;
            ovf_scr_r <= ovf_scr_s;
            cnt_r     <= cnt_s;
        end
    end

    // Registered status and result outputs; results only move in FINISH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {SCR_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            busy_r <= (state_r != IDLE);
            done_r <= (state_r == FINISH);
            if (state_r == FINISH) begin
                bcd_r      <= scratch_r;
                overflow_r <= ovf_scr_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd      = bcd_r;
    assign overflow = overflow_r;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_s;
    logic [DIGITS-1:0] blank_r;

    // Leading-zero mask: a digit blanks only if it and every higher digit are zero
    always_comb begin
        logic run_v;
        blank_s = {DIGITS{1'b0}};
        run_v   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run_v      = run_v & (scratch_r[4*i +: 4] == 4'd0);
            blank_s[i] = run_v;
        end
    end

    // Blank mask register, updated alongside bcd
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blank_r <= {DIGITS{1'b0}};
        end else if (state_r == FINISH) begin
            blank_r <= blank_s;
        end else begin
            blank_r <= blank_r;
        end
    end

    assign blank = blank_r;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle model + directed and random stimulus,
// plus a narrow IN_W=8/DIGITS=2 instance for overflow and blanking corners.
module tb_bin2bcd_seq;

    localparam int IN_W   = 32;
    localparam int DIGITS = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] bin;
    logic        busy, done, overflow;
    logic [39:0] bcd;
    logic        start2;
    logic [7:0]  bin2;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
`ifdef BIN2BCD_BLANK_EN
    logic [9:0]  blank;
    logic [1:0]  blank2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_W(32), .DIGITS(10)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
`ifdef BIN2BCD_BLANK_EN
        , .blank(blank)
`endif
    );

    bin2bcd_seq #(.IN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
`ifdef BIN2BCD_BLANK_EN
        , .blank(blank2)
`endif
    );

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [39:0] to_bcd(input longint unsigned v, input int nd);
        logic [39:0] r = '0;
        longint unsigned t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [9:0] blank_of(input longint unsigned v, input int nd);
        logic [9:0] b = '0;
        for (int i = 1; i < nd; i++) b[i] = (v < pow10(i));
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Cycle-level model: phase counts edges since acceptance
    int          phase = 0;
    logic [31:0] cap = '0;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_ovf = 1'b0;
    logic [39:0] exp_bcd = '0;
    logic [9:0]  exp_blank = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= 0; exp_busy <= 1'b0; exp_done <= 1'b0;
            exp_bcd <= '0; exp_ovf <= 1'b0; exp_blank <= '0;
        end else begin
            exp_busy <= (phase != 0);
            exp_done <= 1'b0;
            if (phase == 0) begin
                if (start) begin
                    cap   <= bin;
                    phase <= 1;
                end
            end else if (phase == IN_W + 1) begin
                exp_done  <= 1'b1;
                exp_bcd   <= to_bcd(cap, DIGITS);
                exp_ovf   <= (cap >= pow10(DIGITS));
                exp_blank <= blank_of(cap, DIGITS);
                phase     <= 0;
            end else begin
                phase <= phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("bcd", bcd, exp_bcd);
            check("overflow", overflow, exp_ovf);
`ifdef BIN2BCD_BLANK_EN
            check("blank", blank, exp_blank);
`endif
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 200);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout actual=%0d cycles expected<200", n);
        end
    endtask

    task automatic convert(input logic [31:0] v, output int lat);
        @(negedge clk); start = 1'b1; bin = v;
        @(negedge clk); start = 1'b0;
        wait_done(lat);
    endtask

    task automatic convert2(input logic [7:0] v);
        int n;
        @(negedge clk); start2 = 1'b1; bin2 = v;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done2 && n < 100);
        check("lat8", n, 9);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        reset = 1'b0; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_bcd", bcd, 64'h0);
        reset = 1'b1;

        check("pin_model_21", to_bcd(21, 10), 40'h21);
        check("pin_model_max", to_bcd(32'hFFFFFFFF, 10), 40'h4294967295);
        check("pin_blank_7", blank_of(7, 2), 10'b10);

        convert(32'd21, n);
        check("lat21", n, 33);
        check("bcd21", bcd, 40'h0000000021);
        check("ovf21", overflow, 1'b0);
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);

        // Back-to-back conversions with start held high
        @(negedge clk); start = 1'b1; bin = 32'd610;
        wait_done(n);
        for (int k = 0; k < 2; k++) begin
            wait_done(n);
            check("b2b_period", n, 34);
            check("b2b_bcd", bcd, 40'h0000000610);
        end
        start = 1'b0;

        convert(32'hFFFFFFFF, n);
        check("bcd_max", bcd, 40'h4294967295);
        check("ovf_max", overflow, 1'b0);
        convert(32'd0, n);
        check("bcd_zero", bcd, 40'h0);

        // bin changes while busy are ignored
        @(negedge clk); start = 1'b1; bin = 32'd123;
        @(negedge clk); bin = 32'd999;
        wait_done(n);
        check("bcd_123", bcd, 40'h123);
        @(negedge clk); start = 1'b0;
        wait_done(n);
        check("lat999", n, 33);
        check("bcd_999", bcd, 40'h999);

        // Async reset in the middle of SHIFT
        @(negedge clk); start = 1'b1; bin = 32'd12345;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_bcd", bcd, 64'h0);
        check("arst_done", done, 1'b0);
        @(negedge clk); @(negedge clk); reset = 1'b1;
        repeat (40) @(negedge clk);
        convert(32'd4096, n);
        check("post_rst_bcd", bcd, 40'h4096);

        // Narrow instance corners
        convert2(8'd255);
        check("n8_ovf255", ovf2, 1'b1);
        convert2(8'd99);
        check("n8_bcd99", bcd2, 8'h99);
        check("n8_ovf99", ovf2, 1'b0);
        convert2(8'd100);
        check("n8_ovf100", ovf2, 1'b1);
        convert2(8'd7);
        check("n8_bcd7", bcd2, 8'h07);
`ifdef BIN2BCD_BLANK_EN
        check("n8_blank7", blank2, 2'b10);
`endif

        // Random traffic, checked every cycle by the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom >> $urandom_range(0, 31);
                2: begin
                    v = 32'(pow10($urandom_range(0, 9)));
                    if ($urandom_range(0, 1) == 1) v = v - 32'd1;
                end
                default: v = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd0;
            endcase
            bin   = v;
            start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
